mux_n_to_1_arb: RTL

//  Parametrised N-channel, WIDTH-bit registered multiplexer with valid/ready handshake.
//  Two select modes:
//   - Direct: software-loaded channel select.
//   - Auto-scan: round-robin among valid channels.

---
 rtl/mux_pkg.sv | 11 +
 rtl/rr_arbiter.sv | 32 +++
 rtl/mux_n_to_1_arb.sv | 100 ++++++++++
 3 files changed

// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared constants and index helper for the channel mux
package mux_pkg;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  function automatic int unsigned next_idx(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin grant starting at ptr
module rr_arbiter #(
  parameter  int NCH  = 4,
  localparam int SELW = $clog2(NCH)
) (
  input  logic [NCH-1:0]  req,
  input  logic [SELW-1:0] ptr,
  input  logic            en,
  output logic [NCH-1:0]  gnt,
  output logic [SELW-1:0] gnt_idx,
  output logic            any
);

  // ptr is always < NCH, so a single conditional subtract gives the wrap
  always_comb begin
    int w_k;
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    w_k     = 0;
    for (int i = 0; i < NCH; i++) begin
      w_k = int'(ptr) + i;
      if (w_k >= NCH) w_k = w_k - NCH;
      if (en && !any && req[w_k]) begin
        gnt[w_k] = 1'b1;
        gnt_idx  = SELW'(w_k);
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_n_to_1_arb.sv
// rtl/mux_n_to_1_arb.sv - N-channel registered mux with direct select or round-robin scan
module mux_n_to_1_arb
  import mux_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int NCH   = 4,
  localparam int SELW  = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  input  logic                 sel_load,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_ch,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 sel_err
);

  logic [SELW-1:0]  r_sel;
  logic [SELW-1:0]  r_rr_ptr;
  logic [WIDTH-1:0] r_out_data;
  logic [SELW-1:0]  r_out_ch;
  logic             r_out_valid;
  logic             r_sel_err;

  logic             w_can_load;
  logic             w_sel_ok;
  logic             w_scan;
  logic             w_accept;
  logic             w_arb_any;
  logic [NCH-1:0]   w_arb_gnt;
  logic [NCH-1:0]   w_dir_gnt;
  logic [NCH-1:0]   w_grant;
  logic [NCH-1:0]   w_take;
  logic [SELW-1:0]  w_arb_idx;
  logic [SELW-1:0]  w_idx;
  logic [WIDTH-1:0] w_ch_data [NCH];

  for (genvar g = 0; g < NCH; g++) begin : g_unpack
    assign w_ch_data[g] = in_data[g*WIDTH +: WIDTH];
  end

  assign w_can_load = !r_out_valid || out_ready;
  assign w_sel_ok   = int'(r_sel) < NCH;
  assign w_scan     = (mode == MODE_SCAN);

  always_comb begin
    w_dir_gnt = '0;
    if (w_can_load && w_sel_ok) w_dir_gnt[r_sel] = 1'b1;
  end

  rr_arbiter #(.NCH(NCH)) u_arb (
    .req     (in_valid),
    .ptr     (r_rr_ptr),
    .en      (w_can_load && w_scan),
    .gnt     (w_arb_gnt),
    .gnt_idx (w_arb_idx),
    .any     (w_arb_any)
  );

  // Grants are suppressed while reset is held so no handshake straddles it
  assign w_grant  = rst ? '0 : (w_scan ? w_arb_gnt : w_dir_gnt);
  assign w_take   = w_grant & in_valid;
  assign w_accept = w_scan ? (w_arb_any && !rst) : (|w_take);
  assign w_idx    = w_scan ? w_arb_idx : r_sel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sel       <= '0;
      r_rr_ptr    <= '0;
      r_out_data  <= '0;
      r_out_ch    <= '0;
      r_out_valid <= 1'b0;
      r_sel_err   <= 1'b0;
    end else begin
      if (sel_load) r_sel <= sel;
      if (!w_scan && !w_sel_ok) r_sel_err <= 1'b1;
      if (w_accept) begin
        r_out_data  <= w_ch_data[w_idx];
        r_out_ch    <= w_idx;
        r_out_valid <= 1'b1;
        if (w_scan) r_rr_ptr <= SELW'(next_idx(32'(w_arb_idx), NCH));
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign in_ready  = w_grant;
  assign out_data  = r_out_data;
  assign out_ch    = r_out_ch;
  assign out_valid = r_out_valid;
  assign sel_err   = r_sel_err;

endmodule
